hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Pipeline control that drives the stage-register enables/flushes consumed by
//  the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Detects load-use hazards, taken-branch/jump redirects from EX, I-/D-cache
//  wait states and halt. Sits beside the datapath, between the caches and the
//  pipeline registers.
// PARAMETERS
//  REG_W      5   register specifier width (regbits_t)
//  CNT_W      32  perf counter width (used only with HAZARD_PERF_EN)
// PORTS
//  CLK            in   1      clock, rising edge
//  nRST           in   1      asynchronous, active-low reset
//  ihit           in   1      I-cache returned instruction this cycle
//  dhit           in   1      D-cache completed access this cycle
//  dREN_ID_EX     in   1      instruction in EX is a load
//  Rt_ID_EX       in   REG_W  load destination in EX
//  Rs_IF_ID       in   REG_W  source reg of instruction in ID
//  Rt_IF_ID       in   REG_W  second source reg of instruction in ID
//  dREN_EX_MEM    in   1      MEM-stage read request
//  dWEN_EX_MEM    in   1      MEM-stage write request
//  redirect_EX    in   1      EX resolved taken branch / jump / jr
//  halt_MEM_WB    in   1      halt reached WB
//  pc_en          out  1      PC update enable
//  enable_IF_ID   out  1      IF/ID load enable
//  flush_IF_ID    out  1      IF/ID load bubble (valid only with enable)
//  enable_ID_EX   out  1      ID/EX load enable
//  flush_ID_EX    out  1      ID/EX load bubble
//  enable_EX_MEM  out  1      EX/MEM load enable
//  flush_EX_MEM   out  1      EX/MEM load bubble
//  enable_MEM_WB  out  1      MEM/WB load enable
//  halt_out       out  1      registered; processor halted
// BEHAVIOUR
//  FSM states: RUN, DWAIT, HALT. Reset (nRST=0, async) -> RUN, halt_out=0.
//  While nRST=0 all outputs 0 (no enables, no flushes).
//  memop = dREN_EX_MEM | dWEN_EX_MEM. luse = dREN_ID_EX & Rt_ID_EX!=0 &
//   (Rt_ID_EX==Rs_IF_ID | Rt_ID_EX==Rt_IF_ID).
//  Transitions (registered, next edge):
//   RUN  -> HALT  if halt_MEM_WB; -> DWAIT if memop & !dhit; else RUN
//   DWAIT-> RUN   if dhit; else DWAIT
//   HALT -> HALT  (exit only by reset); halt_out=1 from first cycle in HALT
//  Outputs (Mealy, same cycle), first matching rule wins:
//   1 HALT state or halt_MEM_WB: all enables 0, flushes 0.
//   2 memop & !dhit (RUN or DWAIT): freeze — all enables 0, flushes 0.
//   3 redirect_EX: pc_en=1; IF/ID en+flush; ID/EX en+flush; EX/MEM en, MEM/WB en.
//   4 luse: pc_en=0, enable_IF_ID=0; ID/EX en+flush (bubble); EX/MEM, MEM/WB en.
//   5 !ihit: pc_en=0; IF/ID en+flush; ID/EX, EX/MEM, MEM/WB en (no flush).
//   6 else all enables 1, flushes 0.
//  redirect_EX overrides luse (load-use consumer is squashed anyway).
//  flush_EX_MEM asserted only when enable_EX_MEM=0 is impossible; it is 0 in all
//   rules above and is reserved (tie 0).
//  dhit with no memop is ignored. Rs/Rt==0 never creates a hazard.
//  Reset mid-DWAIT: immediate return to RUN, outputs 0 until nRST releases.
//  Latency: 0 cycles input->control; state change visible next cycle.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs stall_cnt, flush_cnt, dwait_cnt
//   (CNT_W each, reset 0, saturating at all-ones): stall_cnt +1 per rule-4 or
//   rule-5 cycle, flush_cnt +1 per rule-3 cycle, dwait_cnt +1 per rule-2 cycle.
//   Counters frozen in HALT.
//  Undefined: counters and ports absent; control behaviour identical.
// TESTING
//  1 nRST=0 mid-run -> all outputs 0 same cycle; after release, state RUN, rule 6.
//  2 dREN_ID_EX=1,Rt_ID_EX=5,Rs_IF_ID=5,ihit=1 -> pc_en=0,enable_IF_ID=0,
//    flush_ID_EX=1 one cycle; Rt_ID_EX=0 same case -> no stall.
//  3 dREN_EX_MEM=1,dhit=0 for 3 cycles then dhit=1 -> 3 cycles all enables 0,
//    state DWAIT; dhit cycle enables 1, state back to RUN.
//  4 redirect_EX=1 with luse=1 -> flush_IF_ID=1,flush_ID_EX=1,pc_en=1.
//  5 ihit=0,no hazards -> pc_en=0,flush_IF_ID=1,enable_ID_EX=1.
//  6 halt_MEM_WB=1 -> enables 0 same cycle, halt_out=1 next, held through
//    later ihit/redirect; (HAZARD_PERF_EN) counters stop changing.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline hazard controller. It drives the load enables and bubble
//   (flush) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
//   registers and the PC enable. It reacts to load-use hazards, redirects
//   resolved in EX, I-/D-cache wait states and a halt reaching WB.
//
//   Ports:
//     CLK, nRST                 clock (rising edge), async active-low reset
//     ihit, dhit                I-cache / D-cache completion strobes
//     dREN_ID_EX, Rt_ID_EX      load in EX and its destination register
//     Rs_IF_ID, Rt_IF_ID        source registers of the instruction in ID
//     dREN_EX_MEM, dWEN_EX_MEM  MEM-stage data memory request
//     redirect_EX               taken branch / jump resolved in EX
//     halt_MEM_WB               halt instruction reached WB
//     pc_en, enable_*, flush_*  pipeline register controls (Mealy)
//     halt_out                  registered "processor halted" flag
//
//   Optional feature macro: HAZARD_PERF_EN
//     When defined, adds saturating counters stall_cnt, flush_cnt and
//     dwait_cnt (CNT_W bits each). Control behaviour is identical either way.

module hazard_ctrl_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_ID_EX,
  input  logic [REG_W-1:0] Rt_ID_EX,
  input  logic [REG_W-1:0] Rs_IF_ID,
  input  logic [REG_W-1:0] Rt_IF_ID,
  input  logic             dREN_EX_MEM,
  input  logic             dWEN_EX_MEM,
  input  logic             redirect_EX,
  input  logic             halt_MEM_WB,
  output logic             pc_en,
  output logic             enable_IF_ID,
  output logic             flush_IF_ID,
  output logic             enable_ID_EX,
  output logic             flush_ID_EX,
  output logic             enable_EX_MEM,
  output logic             flush_EX_MEM,
  output logic             enable_MEM_WB,
  output logic             halt_out
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] dwait_cnt
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, HALT = 2'd2} state_t;

  state_t state_reg, state_next;
  logic   halt_reg;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl_unit: CNT_W must be at least 1");
  end

  // Hazard / rule decode shared by next-state, outputs and counters.
  logic memop, mem_stall, luse;
  logic rule_halt, rule_freeze, rule_redirect, rule_luse, rule_imiss;

  assign memop     = dREN_EX_MEM | dWEN_EX_MEM;
  assign mem_stall = memop & ~dhit;
  // Register 0 is hardwired, so a load "to r0" never creates a dependency.
  assign luse      = dREN_ID_EX & (Rt_ID_EX != '0) &
                     ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));

  // Priority chain: each rule only fires when no higher rule does.
  assign rule_halt     = (state_reg == HALT) | halt_MEM_WB;
  assign rule_freeze   = ~rule_halt & mem_stall;
  assign rule_redirect = ~rule_halt & ~mem_stall & redirect_EX;
  assign rule_luse     = ~rule_halt & ~mem_stall & ~redirect_EX & luse;
  assign rule_imiss    = ~rule_halt & ~mem_stall & ~redirect_EX & ~luse & ~ihit;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= RUN;
      halt_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      halt_reg  <= (state_next == HALT);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (halt_MEM_WB)    state_next = HALT;
        else if (mem_stall) state_next = DWAIT;
      end
      DWAIT: begin
        if (dhit) state_next = RUN;
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // Output logic (Mealy). Everything is forced low while reset is asserted.
  always_comb begin
    pc_en         = 1'b0;
    enable_IF_ID  = 1'b0;
    flush_IF_ID   = 1'b0;
    enable_ID_EX  = 1'b0;
    flush_ID_EX   = 1'b0;
    enable_EX_MEM = 1'b0;
    flush_EX_MEM  = 1'b0;  // no rule ever bubbles EX/MEM
    enable_MEM_WB = 1'b0;
    if (nRST && !rule_halt && !rule_freeze) begin
      enable_EX_MEM = 1'b1;
      enable_MEM_WB = 1'b1;
      enable_ID_EX  = 1'b1;
      if (rule_redirect) begin
        pc_en        = 1'b1;
        enable_IF_ID = 1'b1;
        flush_IF_ID  = 1'b1;
        flush_ID_EX  = 1'b1;
      end else if (rule_luse) begin
        // Hold PC and IF/ID; insert a bubble into ID/EX.
        flush_ID_EX  = 1'b1;
      end else if (rule_imiss) begin
        // No instruction fetched: hold PC and feed a bubble into IF/ID.
        enable_IF_ID = 1'b1;
        flush_IF_ID  = 1'b1;
      end else begin
        pc_en        = 1'b1;
        enable_IF_ID = 1'b1;
      end
    end
  end

  assign halt_out = halt_reg;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg, dwait_cnt_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
      dwait_cnt_reg <= '0;
    end else begin
      if ((rule_luse | rule_imiss) && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (rule_redirect && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      if (rule_freeze && (dwait_cnt_reg != '1))
        dwait_cnt_reg <= dwait_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
  assign dwait_cnt = dwait_cnt_reg;
`endif

endmodule
